// File: rtl/fifo_tx_stream.sv
// APB-fed FIFO serialiser: words pushed over APB leave as a bit stream, one bit per RATE_DIV clks, strobed by IQ_rate.
// Latency: first strobe RATE_DIV+1 clks after the start edge; backpressure: pslverr on push to a full FIFO, pready always 1.
module fifo_tx_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int RATE_DIV   = 25,
    parameter int LSB_FIRST  = 1,
    parameter int AFULL_THR  = DEPTH - 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [1:0]            paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [15:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic                  en_IQ,
    output logic                  data_out,
    output logic                  IQ_rate,
    output logic [1:0]            mem_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(RATE_DIV);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [AW:0]    LVL_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    LVL_AFULL = (AW + 1)'(AFULL_THR);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(RATE_DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           level, level_nxt;
    logic [1:0]            mem_state_nxt;
    logic                  underflow;
    state_t                state, state_nxt;
    logic [DW-1:0]         div;
    logic [BW-1:0]         bitcnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  access, full, empty, push, pop, tick, set_uf, clr_uf, cur_bit;

    assign access  = psel & penable;
    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign push    = access & pwrite & (paddr == 2'd0) & ~full;
    assign clr_uf  = access & pwrite & (paddr == 2'd1) & pwdata[0];
    assign pready  = 1'b1;
    assign tick    = (state == SHIFT) && (div == DIV_LAST);
    assign cur_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_WIDTH-1];

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            case (paddr)
                2'd0: pslverr = ~pwrite | full;
                2'd1: begin
                    if (!pwrite) begin
                        prdata[AW:0] = level;
                        prdata[13]   = empty;
                        prdata[14]   = full;
                        prdata[15]   = underflow;
                    end
                end
                default: pslverr = 1'b1;
            endcase
        end
    end

    // The next word is popped on the last bit's tick so back-to-back words keep the bit period.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        set_uf    = 1'b0;
        case (state)
            IDLE: if (en_IQ && !empty) state_nxt = LOAD;
            LOAD: begin
                pop       = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (tick && bitcnt == BIT_LAST) begin
                    if (en_IQ && !empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        set_uf    = en_IQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + 1'b1;
        else if (!push && pop)
            level_nxt = level - 1'b1;

        if (level_nxt == LVL_FULL)
            mem_state_nxt = 2'b11;
        else if (level_nxt >= LVL_AFULL)
            mem_state_nxt = 2'b10;
        else if (level_nxt == '0)
            mem_state_nxt = 2'b00;
        else
            mem_state_nxt = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= pwdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            mem_state <= 2'b00;
            underflow <= 1'b0;
            state     <= IDLE;
            div       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            data_out  <= 1'b0;
            IQ_rate   <= 1'b0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            mem_state <= mem_state_nxt;
            IQ_rate   <= tick;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (set_uf)
                underflow <= 1'b1;
            else if (clr_uf)
                underflow <= 1'b0;
            if (state != SHIFT || tick)
                div <= '0;
            else
                div <= div + 1'b1;
            if (tick) begin
                data_out <= cur_bit;
                bitcnt   <= bitcnt + 1'b1;
                shreg    <= (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
            end
            if (pop) begin
                shreg  <= mem[rptr];
                bitcnt <= '0;
            end
        end
    end
endmodule
